// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Two-source writeback arbiter driving the integer register file
//               write port, with a registered output stage and a pending-write
//               scoreboard used by the issue stage for hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sb_set_en,
  input  logic [4:0]  sb_set_dst,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_dst,
  input  logic [63:0] wb0_data,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_dst,
  input  logic [63:0] wb1_data,
  output logic        rf_wen,
  output logic [4:0]  rf_wdst,
  output logic [63:0] rf_wdata,
  output logic [31:0] sb_busy
);

  // 1 = source 1 is favoured on the next contested cycle
  logic        r_rr_pref;

  logic        w_contest;
  logic        w_pick0;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [4:0]  w_acc_dst;
  logic [63:0] w_acc_data;
  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_next;

  // Grant selection, accepted-write mux and next scoreboard value
  always_comb begin
    w_contest  = wb0_valid && wb1_valid;
    w_pick0    = (FIXED_PRIO != 0) || !r_rr_pref;
    // A lone valid source always wins, so some source is granted whenever any is valid
    w_grant0   = wb0_valid && (!wb1_valid || w_pick0);
    w_grant1   = wb1_valid && !w_grant0;
    w_accept   = w_grant0 || w_grant1;
    w_acc_dst  = w_grant1 ? wb1_dst  : wb0_dst;
    w_acc_data = w_grant1 ? wb1_data : wb0_data;

    // Clear follows the accept (bypass from rf_w* covers the commit gap);
    // applying set after clear makes a same-register set win.
    w_clr_mask  = w_accept ? (32'd1 << w_acc_dst) : 32'd0;
    w_set_mask  = (sb_set_en && (sb_set_dst != 5'd0)) ? (32'd1 << sb_set_dst) : 32'd0;
    w_busy_next = (sb_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
  end

  assign wb0_ready = w_grant0;
  assign wb1_ready = w_grant1;

  // Round-robin pointer, registered write port and scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_pref <= 1'b0;
      rf_wen    <= 1'b0;
      rf_wdst   <= 5'd0;
      rf_wdata  <= 64'd0;
      sb_busy   <= 32'd0;
    end else begin
      // Pointer moves only when both sources competed
      if (w_contest) begin
        r_rr_pref <= w_grant0;
      end
      // Writes to x0 complete the handshake but never reach the register file
      rf_wen <= w_accept && (w_acc_dst != 5'd0);
      if (w_accept) begin
        rf_wdst  <= w_acc_dst;
        rf_wdata <= w_acc_data;
      end
      sb_busy <= w_busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Scoreboard bench for wb_arbiter. Stimulus pushes expected
//               register-file writes into queues; monitors pop and compare
//               whenever rf_wen is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared controls
  logic rst;
  logic sb_set_en;
  logic [4:0] sb_set_dst;

  // Round-robin instance
  logic v0, v1, rdy0, rdy1, wen;
  logic [4:0] d0, d1, wdst;
  logic [63:0] x0, x1, wdata;
  logic [31:0] busy;

  // Fixed-priority instance
  logic f_v0, f_v1, f_rdy0, f_rdy1, f_wen;
  logic [4:0] f_d0, f_d1, f_wdst;
  logic [63:0] f_x0, f_x1, f_wdata;
  logic [31:0] f_busy;

  wb_arbiter #(.FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst(rst), .sb_set_en(sb_set_en), .sb_set_dst(sb_set_dst),
    .wb0_valid(v0), .wb0_ready(rdy0), .wb0_dst(d0), .wb0_data(x0),
    .wb1_valid(v1), .wb1_ready(rdy1), .wb1_dst(d1), .wb1_data(x1),
    .rf_wen(wen), .rf_wdst(wdst), .rf_wdata(wdata), .sb_busy(busy)
  );

  wb_arbiter #(.FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .rst(rst), .sb_set_en(1'b0), .sb_set_dst(5'd0),
    .wb0_valid(f_v0), .wb0_ready(f_rdy0), .wb0_dst(f_d0), .wb0_data(f_x0),
    .wb1_valid(f_v1), .wb1_ready(f_rdy1), .wb1_dst(f_d1), .wb1_data(f_x1),
    .rf_wen(f_wen), .rf_wdst(f_wdst), .rf_wdata(f_wdata), .sb_busy(f_busy)
  );

  // Expected writes: {dst, data}
  logic [68:0] q   [$];
  logic [68:0] f_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the round-robin instance
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      logic [68:0] e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL rr_unexpected_write actual=%0h_%0h required=none", wdst, wdata);
      end else begin
        e = q.pop_front();
        if ({wdst, wdata} !== e) begin
          failures++;
          $display("FAIL rr_write actual=%0h_%0h required=%0h_%0h", wdst, wdata, e[68:64], e[63:0]);
        end
      end
    end
  end

  // Monitor for the fixed-priority instance
  always @(negedge clk) begin
    if (f_wen === 1'b1) begin
      logic [68:0] e;
      checks++;
      if (f_q.size() == 0) begin
        failures++;
        $display("FAIL fp_unexpected_write actual=%0h_%0h required=none", f_wdst, f_wdata);
      end else begin
        e = f_q.pop_front();
        if ({f_wdst, f_wdata} !== e) begin
          failures++;
          $display("FAIL fp_write actual=%0h_%0h required=%0h_%0h", f_wdst, f_wdata, e[68:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_exp;
    logic g;
    rst = 1'b1; sb_set_en = 1'b0; sb_set_dst = 5'd0;
    v0 = 0; v1 = 0; d0 = 0; d1 = 0; x0 = 0; x1 = 0;
    f_v0 = 0; f_v1 = 0; f_d0 = 0; f_d1 = 0; f_x0 = 0; f_x1 = 0;
    repeat (2) cyc();

    // Reset state
    @(negedge clk);
    check("reset_wen", wen, 0);
    check("reset_wdst", wdst, 0);
    check("reset_wdata", wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_rdy0", rdy0, 0);
    check("reset_rdy1", rdy1, 0);
    check("reset_fp_wen", f_wen, 0);
    cyc();
    rst = 1'b0;

    // Scoreboard set then clear through a single wb0 write
    sb_set_en = 1; sb_set_dst = 5;
    cyc();
    sb_set_en = 0;
    v0 = 1; d0 = 5; x0 = 64'hDEAD_BEEF;
    @(negedge clk);
    check("busy5_set", busy[5], 1);
    check("single_rdy0", rdy0, 1);
    check("single_rdy1", rdy1, 0);
    q.push_back({5'd5, x0});
    cyc();
    v0 = 0;
    @(negedge clk);
    check("busy5_clr", busy[5], 0);
    cyc();

    // Round-robin with both sources held valid: grants 0,1,0,1
    rr_exp = 4'b1010;
    v0 = 1; d0 = 3; x0 = 64'hA0;
    v1 = 1; d1 = 4; x1 = 64'hB0;
    for (int i = 0; i < 4; i++) begin
      g = rr_exp[i];
      @(negedge clk);
      check("rr_rdy0", rdy0, !g);
      check("rr_rdy1", rdy1, g);
      if (!g) q.push_back({5'd3, x0});
      else    q.push_back({5'd4, x1});
      cyc();
      if (!g) x0 = x0 + 1;
      else    x1 = x1 + 1;
    end
    v0 = 0; v1 = 0;

    // Write to x0 handshakes but is discarded
    v1 = 1; d1 = 0; x1 = 64'h1;
    @(negedge clk);
    check("x0_rdy1", rdy1, 1);
    cyc();
    v1 = 0;
    @(negedge clk);
    check("x0_wen", wen, 0);
    check("x0_busy", busy, 32'h0);
    cyc();

    // Same-register set and clear: set wins
    sb_set_en = 1; sb_set_dst = 7;
    cyc();
    v0 = 1; d0 = 7; x0 = 64'h77;
    @(negedge clk);
    check("pre_busy7", busy, 32'h80);
    check("setclr_rdy0", rdy0, 1);
    q.push_back({5'd7, x0});
    cyc();
    sb_set_en = 0; v0 = 0;
    @(negedge clk);
    check("setclr_same", busy, 32'h80);
    cyc();

    // Set of x0 has no effect
    sb_set_en = 1; sb_set_dst = 0;
    cyc();
    sb_set_en = 0;
    @(negedge clk);
    check("set_x0", busy, 32'h80);
    cyc();

    // Set r9 and clear r7 in the same cycle
    sb_set_en = 1; sb_set_dst = 9;
    v1 = 1; d1 = 7; x1 = 64'h7777;
    @(negedge clk);
    check("diff_rdy1", rdy1, 1);
    q.push_back({5'd7, x1});
    cyc();
    sb_set_en = 0; v1 = 0;
    @(negedge clk);
    check("setclr_diff", busy, 32'h200);
    cyc();

    // Build busy = 0xF0, retiring r9 on the first cycle
    for (int r = 4; r < 8; r++) begin
      sb_set_en = 1; sb_set_dst = 5'(r);
      if (r == 4) begin
        v0 = 1; d0 = 9; x0 = 64'h99;
        @(negedge clk);
        check("build_rdy0", rdy0, 1);
        q.push_back({5'd9, x0});
      end
      cyc();
      v0 = 0;
    end
    sb_set_en = 0;
    @(negedge clk);
    check("busy_f0", busy, 32'hF0);
    cyc();

    // Contested cycle grants 0 (pointer then favours 1), then reset
    v0 = 1; d0 = 2; x0 = 64'hC0;
    v1 = 1; d1 = 3; x1 = 64'hD0;
    @(negedge clk);
    check("prerst_rdy0", rdy0, 1);
    check("prerst_rdy1", rdy1, 0);
    q.push_back({5'd2, x0});
    cyc();
    x0 = 64'hC1;
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    check("rst_wen", wen, 0);
    check("rst_busy", busy, 32'h0);
    check("rst_rr_rdy0", rdy0, 1);
    check("rst_rr_rdy1", rdy1, 0);
    q.push_back({5'd2, x0});
    cyc();
    v0 = 0;
    @(negedge clk);
    check("postrst_rdy1", rdy1, 1);
    q.push_back({5'd3, x1});
    cyc();
    v1 = 0;

    // Fixed priority: source 0 wins while valid, source 1 follows
    f_v0 = 1; f_d0 = 3; f_x0 = 64'hE0;
    f_v1 = 1; f_d1 = 4; f_x1 = 64'hF0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("fp_rdy0", f_rdy0, 1);
      check("fp_rdy1", f_rdy1, 0);
      f_q.push_back({5'd3, f_x0});
      cyc();
      f_x0 = f_x0 + 1;
    end
    f_v0 = 0;
    @(negedge clk);
    check("fp_late_rdy1", f_rdy1, 1);
    f_q.push_back({5'd4, f_x1});
    cyc();
    f_v1 = 0;

    repeat (3) cyc();
    check("rr_queue_empty", q.size(), 0);
    check("fp_queue_empty", f_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side producer for the integer register file; drives its single write port (rf_wen/rf_wdst/rf_wdata).
- Arbitrates two writeback sources into that port: source 0 is the ALU/branch pipe, source 1 is the LSU/mul-div unit.
- Registers the winning write one cycle before it reaches the register file.
- Maintains a pending-write scoreboard (sb_busy) that the issue stage uses for RAW/WAW hazard stalls.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between sources; 1 = source 0 always wins.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- sb_set_en  input  1  issue stage dispatched an instruction that writes sb_set_dst
- sb_set_dst  input  5  destination register of the dispatched instruction
- wb0_valid  input  1  source 0 has a result
- wb0_ready  output  1  source 0 result accepted this cycle
- wb0_dst  input  5  source 0 destination register
- wb0_data  input  64  source 0 result
- wb1_valid  input  1  source 1 has a result
- wb1_ready  output  1  source 1 result accepted this cycle
- wb1_dst  input  5  source 1 destination register
- wb1_data  input  64  source 1 result
- rf_wen  output  1  register file write enable
- rf_wdst  output  5  register file write address
- rf_wdata  output  64  register file write data
- sb_busy  output  32  bit n = 1 means register n has a write outstanding

Behaviour:
- Reset (clk edge with rst=1): rf_wen=0, rf_wdst=0, rf_wdata=0, sb_busy=0, round-robin pointer favours source 0.
- rst overrides all other activity in the same cycle; any in-flight handshake is dropped. Sources must deassert valid during reset.

Handshake:
- Accept occurs when wbN_valid && wbN_ready.
- wbN_ready is combinational from both valids and the round-robin pointer. At most one ready is high per cycle.
- Ready is high only when that source's valid is high.
- Once a source raises valid, it must hold valid, dst and data stable until accepted. valid must not depend on ready.

Arbitration:
- Only one source valid: that source is granted.
- Both valid, FIXED_PRIO=1: source 0 is granted.
- Both valid, FIXED_PRIO=0: the source not granted in the most recent contested cycle is granted.
- The round-robin pointer updates only on cycles where both sources are valid.
- Guaranteed bound: with round-robin, a waiting source is accepted within 2 cycles.
- No cycle with a valid source goes without a grant; the block never back-pressures both sources at once.

Output stage (1-cycle latency):
- The accepted result appears on rf_wen/rf_wdst/rf_wdata on the cycle after the accept. The register file commits it at the following clock edge.
- No accept: rf_wen=0. rf_wdst and rf_wdata hold their previous values.
- Accept with dst==0: the handshake completes but rf_wen=0, i.e. writes to x0 are discarded.
- rf_w* are registered outputs and may be used directly as a bypass source by the issue stage.

Scoreboard:
- sb_busy is a registered vector.
- Set: sb_set_en with sb_set_dst=d, d!=0, sets bit d at the next edge.
- Clear: an accept (either source) with dst=d clears bit d at the next edge. The clear is tied to the accept, not to the RF commit, because the bypass covers the one-cycle gap.
- Same-cycle set and clear on the same d: set wins, so the bit stays 1 (the new producer is outstanding).
- Set and clear on different registers in the same cycle both take effect.
- sb_busy[0] is always 0.
- Setting an already-busy register leaves it at 1. The issue stage must stall WAW hazards; the block does not count multiple producers per register.
- Clearing a non-busy register leaves it at 0 and raises no error.

Test Plan:
- Reset -> rf_wen=0, rf_wdst=0, rf_wdata=0, sb_busy=32'h0; wb0_ready=0 and wb1_ready=0 with both valids low.
- sb_set_en with dst=5; next cycle wb0 valid with dst=5, data=64'hDEAD_BEEF -> wb0_ready=1 that cycle; next cycle rf_wen=1, rf_wdst=5, rf_wdata=64'hDEADBEEF; sb_busy[5] goes 1 then 0.
- FIXED_PRIO=0, both sources held valid with wb0 dst=3 and wb1 dst=4 -> grants alternate 0,1; rf_wdst sequence 3,4. Repeat with FIXED_PRIO=1 -> wb0 granted first, wb1 granted the cycle after wb0 drops valid.
- wb1 valid with dst=0, data=64'h1 -> wb1_ready=1; next cycle rf_wen=0; sb_busy unchanged.
- Same cycle: sb_set_en dst=7 and wb0 accept dst=7, with sb_busy[7]=1 beforehand -> sb_busy[7] stays 1. A separate set of dst=0 -> sb_busy[0] stays 0.
- rst asserted while both sources are valid and sb_busy=32'h0000_00F0 -> next cycle rf_wen=0 and sb_busy=0; after rst falls, arbitration resumes favouring source 0.
